// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scanner with debouncer handshake.
// Scans rows one-cold, locks the first pressed key, and reports it once the debouncer confirms.
module keypad_scanner #(
    parameter int SETTLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       req,
    output logic [3:0] active_row,
    output logic [3:0] active_col,
    input  logic       high,
    input  logic       low,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SETTLE);
    // nibble {row,col} of this constant holds the hex legend of that key
    localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

    state_t        state, state_d;
    logic [1:0]    row, row_d, lrow, lrow_d, lcol, lcol_d, low_col;
    logic [DW-1:0] dwell, dwell_d;
    logic [3:0]    col_s1, col_s2, code_d;
    logic          valid_d;

    assign low_col    = !col_s2[0] ? 2'd0 : !col_s2[1] ? 2'd1 : !col_s2[2] ? 2'd2 : 2'd3;
    assign row_n      = ~(4'b0001 << row);
    assign req        = state != SCAN;
    assign active_row = req ? ~(4'b0001 << lrow) : 4'hf;
    assign active_col = req ? ~(4'b0001 << lcol) : 4'hf;
    assign key_held   = state == HELD;

    always_comb begin
        state_d = state;
        row_d   = row;
        dwell_d = dwell;
        lrow_d  = lrow;
        lcol_d  = lcol;
        code_d  = key_code;
        valid_d = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DW'(SETTLE - 1)) begin
                    dwell_d = '0;
                    if (col_s2 != 4'hf) begin
                        state_d = CONFIRM;
                        lrow_d  = row;
                        lcol_d  = low_col;
                    end else begin
                        row_d = row + 2'd1;
                    end
                end else begin
                    dwell_d = dwell + DW'(1);
                end
            end
            CONFIRM: begin
                if (high) begin
                    state_d = HELD;
                    code_d  = KMAP[{lrow, lcol, 2'b00} +: 4];
                    valid_d = 1'b1;
                end else if (low) begin
                    state_d = SCAN;
                    row_d   = row + 2'd1;
                    dwell_d = '0;
                end
            end
            HELD: begin
                if (low) begin
                    state_d = SCAN;
                    row_d   = row + 2'd1;
                    dwell_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SCAN;
            row       <= '0;
            dwell     <= '0;
            lrow      <= '0;
            lcol      <= '0;
            col_s1    <= 4'hf;
            col_s2    <= 4'hf;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            dwell     <= dwell_d;
            lrow      <= lrow_d;
            lcol      <= lcol_d;
            col_s1    <= col_n;
            col_s2    <= col_s1;
            key_code  <= code_d;
            key_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios checked against a cycle model and literal expectations.
module tb_keypad_scanner;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        high = 1'b0;
    logic        low = 1'b0;
    logic [15:0] keys = '0;
    logic [3:0]  col_n, row_n, active_row, active_col, key_code;
    logic        req, key_valid, key_held;
    int          errors = 0;
    int          checks = 0;

    keypad_scanner #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rstn(rstn), .col_n(col_n), .row_n(row_n), .req(req),
        .active_row(active_row), .active_col(active_col), .high(high), .low(low),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // physical matrix: a pressed key shorts its column to its row while that row is driven low
    always_comb begin
        col_n = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    // reference model: mode 0 scanning, 1 awaiting debouncer, 2 key held
    int          kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [3:0]  h1, h2, m_code;
    logic        m_valid;
    int          m_mode, m_row, m_cnt, m_lr, m_lc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h1 <= 4'hf; h2 <= 4'hf; m_code <= '0; m_valid <= 1'b0;
            m_mode <= 0; m_row <= 0; m_cnt <= 0; m_lr <= 0; m_lc <= 0;
        end else begin
            h1 <= col_n;
            h2 <= h1;
            m_valid <= 1'b0;
            if (m_mode == 0) begin
                if (m_cnt == SETTLE - 1) begin
                    m_cnt <= 0;
                    if (h2 != 4'hf) begin
                        m_mode <= 1; m_lr <= m_row; m_lc <= lowest(h2);
                    end else m_row <= (m_row + 1) % 4;
                end else m_cnt <= m_cnt + 1;
            end else if (m_mode == 1 && high) begin
                m_mode <= 2; m_code <= 4'(kmap[m_lr*4+m_lc]); m_valid <= 1'b1;
            end else if (low) begin
                m_mode <= 0; m_row <= (m_row + 1) % 4; m_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("row_n", row_n, 4'(~(1 << m_row)));
            chk("req", {3'b0, req}, {3'b0, m_mode != 0});
            chk("active_row", active_row, m_mode != 0 ? 4'(~(1 << m_lr)) : 4'hf);
            chk("active_col", active_col, m_mode != 0 ? 4'(~(1 << m_lc)) : 4'hf);
            chk("key_code", key_code, m_code);
            chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
            chk("key_held", {3'b0, key_held}, {3'b0, m_mode == 2});
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 60 && !req; i++) @(negedge clk);
        chk("wait_req", {3'b0, req}, 4'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (key_valid) break;
        end
        chk("wait_valid", {3'b0, key_valid}, 4'd1);
    endtask

    task automatic release_key(input logic [3:0] exp_row_n);
        high = 1'b0; low = 1'b1; keys = '0;
        @(posedge clk); #1;
        chk("rel_req", {3'b0, req}, 4'd0);
        chk("rel_held", {3'b0, key_held}, 4'd0);
        chk("rel_row_n", row_n, exp_row_n);
        @(negedge clk);
        low = 1'b0;
    endtask

    task automatic dwell_after_reset();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("dwell_row_n", row_n, k < 4 ? 4'b1110 : 4'b1101);
        end
    endtask

    initial begin
        #3;
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_req", {3'b0, req}, 4'd0);
        chk("rst_active", active_row & active_col, 4'hf);
        chk("rst_code", key_code, 4'h0);
        chk("rst_flags", {2'b0, key_valid, key_held}, 4'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        // idle scan: row advances every SETTLE edges, nothing requested
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk("idle_row_n", row_n, 4'(~(1 << ((k / 4) % 4))));
            chk("idle_req", {3'b0, req}, 4'd0);
        end
        // r1/c2 -> 6
        @(negedge clk);
        keys[6] = 1'b1;
        wait_req();
        chk("r1c2_arow", active_row, 4'b1101);
        chk("r1c2_acol", active_col, 4'b1011);
        high = 1'b1;
        wait_valid();
        chk("r1c2_code", key_code, 4'h6);
        chk("r1c2_held", {3'b0, key_held}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("r1c2_once", {3'b0, key_valid}, 4'd0);
        end
        release_key(4'b1011);
        // r0/c0 aborted by low before high
        keys[0] = 1'b1;
        wait_req();
        chk("r0c0_arow", active_row, 4'b1110);
        chk("r0c0_acol", active_col, 4'b1110);
        release_key(4'b1101);
        chk("abort_code", key_code, 4'h6);
        chk("abort_valid", {3'b0, key_valid}, 4'd0);
        // r3 with c1 and c3 -> lowest column c1 -> 0
        keys[13] = 1'b1; keys[15] = 1'b1;
        wait_req();
        chk("r3_arow", active_row, 4'b0111);
        chk("r3_acol", active_col, 4'b1101);
        high = 1'b1;
        wait_valid();
        chk("r3_code", key_code, 4'h0);
        release_key(4'b1110);
        // r2/c0 -> 7, then reset mid-HELD
        keys[8] = 1'b1;
        wait_req();
        high = 1'b1;
        wait_valid();
        chk("r2c0_code", key_code, 4'h7);
        @(negedge clk);
        rstn = 1'b0; high = 1'b0; keys = '0;
        #1;
        chk("arst_req", {3'b0, req}, 4'd0);
        chk("arst_held", {3'b0, key_held}, 4'd0);
        chk("arst_row_n", row_n, 4'b1110);
        chk("arst_code", key_code, 4'h0);
        chk("arst_active", active_row & active_col, 4'hf);
        @(negedge clk);
        rstn = 1'b1;
        dwell_after_reset();
        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 16, meaning clk cycles each row is driven before its columns are sampled (legal range 4..65535).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port col_n, input, 4, raw keypad columns, pulled up, low = key pressed on the driven row.
REQ-005 SHALL have port row_n, output, 4, keypad row drive, one-cold.
REQ-006 SHALL have port req, output, 1, debounce request to the debouncer block.
REQ-007 SHALL have port active_row, output, 4, one-cold copy of the locked row, for the debouncer.
REQ-008 SHALL have port active_col, output, 4, one-cold locked column, for the debouncer.
REQ-009 SHALL have port high, input, 1, debouncer: valid press confirmed.
REQ-010 SHALL have port low, input, 1, debouncer: valid release (or no-press) confirmed.
REQ-011 SHALL have port key_code, output, 4, hex value of the last accepted key.
REQ-012 SHALL have port key_valid, output, 1, one-cycle pulse when key_code is updated.
REQ-013 SHALL have port key_held, output, 1, high while an accepted key remains pressed.

Function
REQ-014 SHALL pass col_n through a 2-flop synchronizer; all column decisions SHALL use the synchronized value only.
REQ-015 SHALL implement states SCAN, CONFIRM, HELD.
REQ-016 SCAN: SHALL drive one row low for SETTLE cycles using a dwell counter of width ceil(log2(SETTLE)); on the final dwell cycle, SHALL sample the synchronized columns.
REQ-017 SCAN, no column low at sample: SHALL advance to the next row in order 0,1,2,3,0 (row_n 1110,1101,1011,0111) and restart the dwell count.
REQ-018 SCAN, one or more columns low at sample: SHALL lock the current row and the lowest-index low column, and go to CONFIRM next cycle.
REQ-019 CONFIRM and HELD: SHALL hold row_n on the locked row and assert req; active_row and active_col SHALL be constant.
REQ-020 In SCAN, req SHALL be 0 and active_row/active_col SHALL be 4'b1111.
REQ-021 CONFIRM, high=1: SHALL go to HELD, load key_code, and pulse key_valid for exactly one cycle, on the cycle after high is seen.
REQ-022 CONFIRM, low=1 with high=0: SHALL abort to SCAN on the next row with no key_valid; if both are set, high SHALL win.
REQ-023 HELD: key_held SHALL be 1; high SHALL be ignored; low=1 SHALL return to SCAN on the next row, drop req, and clear key_held.
REQ-024 Presses of other keys during CONFIRM or HELD SHALL be ignored; key_valid SHALL fire at most once per lock.
REQ-025 key_code map (row,col -> hex): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (col0..col3).
REQ-026 key_code SHALL hold its value until the next accepted key.
REQ-027 req SHALL be deasserted for at least one cycle between consecutive locks, so the debouncer restarts.

Reset
REQ-028 While rstn=0, the block SHALL immediately be in SCAN with: row_n=1110, dwell count 0, req=0, active_row=active_col=1111, key_code=0, key_valid=0, key_held=0, synchronizer flops=1111.
REQ-029 Reset asserted in CONFIRM or HELD SHALL drop req asynchronously with no key_valid; scanning SHALL restart at row 0 on the first clock edge after release.

Verification
REQ-030 No keys pressed, SETTLE=4 -> row_n cycles 1110,1101,1011,0111 every 4 cycles; req stays 0; key_valid never pulses.
REQ-031 Hold r1/c2 (col_n=1011 while row_n=1101), debouncer model asserts high -> req=1, active_row=1101, active_col=1011, then one key_valid pulse with key_code=6, key_held=1.
REQ-032 From REQ-031, assert low -> req=0 within 1 cycle, key_held=0, scan resumes at row 2.
REQ-033 r3 with col_n=0101 (c1 and c3 pressed), high -> active_col=1101, key_code=0.
REQ-034 Lock r0/c0, assert low before any high -> no key_valid; key_code unchanged; scan resumes at row 1.
REQ-035 rstn pulsed low mid-HELD -> req, key_held and row_n reach their reset values without a clock edge; key_code=0; after release, row 0 is driven and one SETTLE dwell elapses before the first sample.
